// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver. It synchronises rx into clk, samples each bit at its centre,
// and emits a one-cycle rx_data_ready per good frame or frame_error when the stop bit is 0.
module uart_rx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_data_ready,
  output logic       frame_error
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  if (CLKS_PER_BIT < 4) begin : g_cpb_check
    $error("uart_rx: CLK_FREQ/BAUD must be at least 4");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] clk_cnt_r;
  logic [2:0]       bit_idx_r;
  logic [7:0]       shreg_r;
  logic             rx_meta_r;
  logic             rx_sync_r;
  logic             rx_prev_r;
  logic             fall_s;

  // Two-flop synchroniser plus a delay flop used for falling-edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // A held-low line never re-arms; only a genuine high-to-low transition starts a frame.
  assign fall_s = rx_prev_r & ~rx_sync_r;

  // Frame state machine with registered data and status pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      clk_cnt_r     <= '0;
      bit_idx_r     <= 3'd0;
      shreg_r       <= 8'h00;
      rx_data       <= 8'h00;
      rx_data_ready <= 1'b0;
      frame_error   <= 1'b0;
    end else begin
      rx_data_ready <= 1'b0;
      frame_error   <= 1'b0;
      case (state_r)
        IDLE: begin
          clk_cnt_r <= '0;
          bit_idx_r <= 3'd0;
          if (fall_s) begin
            state_r <= START;
          end else begin
            state_r <= IDLE;
          end
        end
        START: begin
          if (clk_cnt_r == HALF_LAST) begin
            clk_cnt_r <= '0;
            bit_idx_r <= 3'd0;
            // Line back high at mid-start means it was a glitch, not a frame.
            state_r   <= rx_sync_r ? IDLE : DATA;
          end else begin
            clk_cnt_r <= clk_cnt_r + CNT_ONE;
          end
        end
        DATA: begin
          if (clk_cnt_r == BIT_LAST) begin
            clk_cnt_r <= '0;
            shreg_r   <= {rx_sync_r, shreg_r[7:1]};
            if (bit_idx_r == 3'd7) begin
              state_r <= STOP;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
            end
          end else begin
            clk_cnt_r <= clk_cnt_r + CNT_ONE;
          end
        end
        STOP: begin
          if (clk_cnt_r == BIT_LAST) begin
            clk_cnt_r <= '0;
            // Returning at mid-stop lets a start bit that follows immediately be caught.
            state_r   <= IDLE;
            if (rx_sync_r) begin
              rx_data       <= shreg_r;
              rx_data_ready <= 1'b1;
            end else begin
              frame_error   <= 1'b1;
            end
          end else begin
            clk_cnt_r <= clk_cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r   <= IDLE;
          clk_cnt_r <= '0;
          bit_idx_r <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames against an expected-event list that holds outcome, byte and
// arrival window for each frame sent; a per-cycle checker compares the DUT outputs to it.
module tb_uart_rx;

  localparam int CPB     = 434;
  localparam int LAT_NOM = 4126;
  localparam int GAP_NOM = 10 * CPB;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       rx    = 1'b1;
  logic [7:0] rx_data;
  logic       rx_data_ready;
  logic       frame_error;

  uart_rx #(.CLK_FREQ(50_000_000), .BAUD(115200)) dut (
    .clk           (clk),
    .reset         (reset),
    .rx            (rx),
    .rx_data       (rx_data),
    .rx_data_ready (rx_data_ready),
    .frame_error   (frame_error)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         err;
    logic [7:0] data;
    int         start;
    bit         chk_lat;
    bit         chk_gap;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        cur_e;
  logic [7:0] exp_hold   = 8'h00;
  int         last_pulse = 0;
  int         n_ready    = 0;
  int         n_ferr     = 0;
  int         n_checks   = 0;
  int         n_errors   = 0;

  task automatic chk(input string name, input bit ok, input longint act, input longint req);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Hold rx at a level for n clock cycles; always returns at posedge+1.
  task automatic drive(input logic b, input int n);
    rx = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int cpb,
                            input bit chk_lat, input bit chk_gap);
    ev_t e;
    e.err     = !stop_bit;
    e.data    = d;
    e.start   = cyc + 1;
    e.chk_lat = chk_lat;
    e.chk_gap = chk_gap;
    exp_q.push_back(e);
    drive(1'b0, cpb);
    for (int i = 0; i < 8; i++) drive(d[i], cpb);
    drive(stop_bit, cpb);
  endtask

  // Per-cycle comparison of the DUT against the expected-event list
  always @(negedge clk) begin
    if (reset) begin
      exp_hold = 8'h00;
    end else begin
      chk("pulses_exclusive", !(rx_data_ready && frame_error), {rx_data_ready, frame_error}, 0);
      if (rx_data_ready || frame_error) begin
        if (rx_data_ready) n_ready++;
        if (frame_error) n_ferr++;
        chk("unexpected_pulse", exp_q.size() != 0, {rx_data_ready, frame_error}, 0);
        if (exp_q.size() != 0) begin
          cur_e = exp_q.pop_front();
          chk("pulse_kind", frame_error == cur_e.err, frame_error, cur_e.err);
          if (!cur_e.err) exp_hold = cur_e.data;
          chk("rx_data_on_pulse", rx_data == exp_hold, rx_data, exp_hold);
          if (cur_e.chk_lat)
            chk("latency", (cyc - cur_e.start >= LAT_NOM - 1) && (cyc - cur_e.start <= LAT_NOM + 1),
                cyc - cur_e.start, LAT_NOM);
          if (cur_e.chk_gap)
            chk("pulse_spacing", (cyc - last_pulse >= GAP_NOM - 1) && (cyc - last_pulse <= GAP_NOM + 1),
                cyc - last_pulse, GAP_NOM);
        end
        last_pulse = cyc;
      end else begin
        chk("rx_data_hold", rx_data == exp_hold, rx_data, exp_hold);
      end
    end
  end

  initial begin
    repeat (5) @(posedge clk);
    #1;
    chk("reset_rx_data", rx_data == 8'h00, rx_data, 8'h00);
    chk("reset_pulses", {rx_data_ready, frame_error} == 2'b00, {rx_data_ready, frame_error}, 0);
    reset = 1'b0;

    // Idle line
    drive(1'b1, 10000);
    chk("t1_rx_data", rx_data == 8'h00, rx_data, 8'h00);
    chk("t1_no_events", n_ready + n_ferr == 0, n_ready + n_ferr, 0);

    // Single frame
    send_frame(8'hA5, 1'b1, CPB, 1'b1, 1'b0);
    drive(1'b1, 600);
    chk("t2_rx_data", rx_data == 8'hA5, rx_data, 8'hA5);
    chk("t2_ready_count", n_ready == 1, n_ready, 1);

    // Back-to-back frames with zero idle time
    send_frame(8'h01, 1'b1, CPB, 1'b1, 1'b0);
    send_frame(8'h12, 1'b1, CPB, 1'b1, 1'b1);
    send_frame(8'h34, 1'b1, CPB, 1'b1, 1'b1);
    drive(1'b1, 600);
    chk("t3_rx_data", rx_data == 8'h34, rx_data, 8'h34);
    chk("t3_ready_count", n_ready == 4, n_ready, 4);

    // Sender clock at -3% and +3%
    send_frame(8'hC3, 1'b1, 421, 1'b0, 1'b0);
    drive(1'b1, 600);
    chk("tol_fast_rx_data", rx_data == 8'hC3, rx_data, 8'hC3);
    send_frame(8'h96, 1'b1, 447, 1'b0, 1'b0);
    drive(1'b1, 600);
    chk("tol_slow_rx_data", rx_data == 8'h96, rx_data, 8'h96);

    // Short low glitch is rejected
    drive(1'b0, 100);
    drive(1'b1, 600);
    chk("t4_glitch_ignored", n_ready == 6 && n_ferr == 0, n_ready * 100 + n_ferr, 600);
    send_frame(8'h5A, 1'b1, CPB, 1'b1, 1'b0);
    drive(1'b1, 600);
    chk("t4_rx_data", rx_data == 8'h5A, rx_data, 8'h5A);

    // Bad stop bit followed by a long break
    send_frame(8'hA5, 1'b1, CPB, 1'b1, 1'b0);
    drive(1'b1, 600);
    send_frame(8'h3C, 1'b0, CPB, 1'b1, 1'b0);
    drive(1'b0, 20000);
    chk("t5_ferr_count", n_ferr == 1, n_ferr, 1);
    chk("t5_ready_count", n_ready == 8, n_ready, 8);
    chk("t5_rx_data_kept", rx_data == 8'hA5, rx_data, 8'hA5);
    drive(1'b1, 600);
    send_frame(8'h3C, 1'b1, CPB, 1'b1, 1'b0);
    drive(1'b1, 600);
    chk("t5_rx_data", rx_data == 8'h3C, rx_data, 8'h3C);

    // Reset during data bit 4 of 8'hFF
    drive(1'b0, CPB);
    drive(1'b1, 4 * CPB + 200);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    drive(1'b1, 4 * CPB - 203 + 600);
    chk("t6_rx_data_reset", rx_data == 8'h00, rx_data, 8'h00);
    chk("t6_no_pulse", n_ready == 9 && n_ferr == 1, n_ready * 100 + n_ferr, 901);
    send_frame(8'h7E, 1'b1, CPB, 1'b1, 1'b0);
    drive(1'b1, 600);
    chk("t6_rx_data", rx_data == 8'h7E, rx_data, 8'h7E);
    chk("t6_ready_count", n_ready == 10, n_ready, 10);

    chk("all_events_seen", exp_q.size() == 0, exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
